// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-memory responder: LSU op encodings and FSM states.
// Every file in the slice imports this package instead of redefining them.
package data_mem_resp_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between a load-store initiator and the data-memory responder.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  lsu_op_e           req_op;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_resp_lane_align.sv
// Combinational byte-lane handling: load extract/extend, store byte-enables and lane replication.
// Misaligned offsets are reported and also forced down to natural alignment.
module dmem_lane_align
  import data_mem_resp_pkg::*;
(
  input  lsu_op_e           op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic              is_store,
  output logic              misaligned,
  output logic [3:0]        wbe,
  output logic [DATA_W-1:0] wword,
  output logic [DATA_W-1:0] rdata
);

  logic [1:0]  off_eff;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_store   = op_is_store(op);
    misaligned = 1'b0;
    off_eff    = off;
    wbe        = 4'b0000;
    wword      = '0;
    rdata      = '0;

    case (op)
      LSU_LH, LSU_LHU, LSU_SH: begin
        misaligned = off[0];
        off_eff    = {off[1], 1'b0};
      end
      LSU_LW, LSU_SW: begin
        misaligned = (off != 2'b00);
        off_eff    = 2'b00;
      end
      default: ;
    endcase

    byte_sel = rword[{off_eff, 3'b000} +: 8];
    half_sel = rword[{off_eff[1], 4'b0000} +: 16];

    case (op)
      LSU_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: rdata = {24'd0, byte_sel};
      LSU_LH:  rdata = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: rdata = {16'd0, half_sel};
      LSU_LW:  rdata = rword;
      LSU_SB: begin
        wbe   = 4'b0001 << off_eff;
        wword = {4{wdata[7:0]}};
      end
      LSU_SH: begin
        wbe   = off_eff[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      LSU_SW: begin
        wbe   = 4'b1111;
        wword = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Single-ported data memory behind a valid/ready request/response handshake, WAIT_CYCLES extra wait states.
// DMEM_MISALIGN_ERR_EN: misaligned half/word accesses flag resp_err instead of being forced aligned.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
)(
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  lsu_op_e           op_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept, enter_resp, mem_we, err;
  lsu_op_e           acc_op;
  logic [DATA_W-1:0] acc_addr, acc_wdata;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rword, wword, load_data;
  logic [3:0]        wbe;
  logic              is_store, misaligned;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  // With zero wait states the access completes on the accepting edge, so use the live request.
  assign acc_op    = (state_q == ST_IDLE) ? bus.req_op    : op_q;
  assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

  assign idx   = acc_addr[IDX_W+1:2];
  assign rword = mem[idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr[DATA_W-1:IDX_W+2];

  dmem_lane_align u_align (
    .op         (acc_op),
    .off        (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .rword      (rword),
    .is_store   (is_store),
    .misaligned (misaligned),
    .wbe        (wbe),
    .wword      (wword),
    .rdata      (load_data)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign err = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= LSU_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (err || is_store) ? '0 : load_data;
        err_q   <= err;
      end
    end
  end

  // Stores commit only on the edge entering RESP, so a reset during WAIT drops them.
  assign mem_we = enter_resp && is_store && !err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed vector table, stall/reset-abort sequences, random traffic vs a byte-array model.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  localparam int DEPTH = 64;
  localparam int W     = 3;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_resp_if bus();

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_b [DEPTH*4];

  typedef struct {
    lsu_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00000111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size-aligned accesses, wrap modulo memory size.
  task automatic model_apply(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
    int size, base;
    bit st, sgn;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    st  = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    sgn = (op == LSU_LB) || (op == LSU_LH);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: size = 1;
      LSU_LH, LSU_LHU, LSU_SH: size = 2;
      default:                 size = 4;
    endcase
    base = int'(addr[AW-1:0]);
    if (base % size != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      er = 1'b1;
      return;
`else
      base = base - (base % size);
`endif
    end
    if (st) begin
      for (int k = 0; k < size; k++) mem_b[base+k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = mem_b[base+k];
      if (sgn && v[8*size-1]) for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
      rd = v;
    end
  endtask

  task automatic access(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = LSU_SW;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata", bus.resp_rdata, rd);
      chk("stall_err", 32'(bus.resp_err), 32'(er));
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic run_model(input string name, input lsu_op_e op, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    model_apply(op, addr, wd, erd, eer);
    access(op, addr, wd, hold, rd, er, lat);
    chk({name, "_rdata"}, rd, erd);
    chk({name, "_err"}, 32'(er), 32'(eer));
    chk({name, "_lat"}, 32'(lat), 32'(W + 1));
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, drd;
    logic er, der;
    int lat;

    bus.req_valid  = 1'b0;
    bus.req_op     = LSU_LB;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) run_model("preload", LSU_SW, 32'(i * 4), pattern(i), 0);

    tbl.push_back('{LSU_SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{LSU_LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{LSU_SB,  32'h11,  32'h000000AA, 32'h0,        1'b0});
    tbl.push_back('{LSU_LW,  32'h10,  32'h0,        32'hDEADAAEF, 1'b0});
    tbl.push_back('{LSU_LB,  32'h11,  32'h0,        32'hFFFFFFAA, 1'b0});
    tbl.push_back('{LSU_LBU, 32'h11,  32'h0,        32'h000000AA, 1'b0});
    tbl.push_back('{LSU_SH,  32'h12,  32'h00008001, 32'h0,        1'b0});
    tbl.push_back('{LSU_LH,  32'h12,  32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{LSU_LHU, 32'h12,  32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{LSU_LW,  32'h10,  32'h0,        32'h8001AAEF, 1'b0});
`ifdef DMEM_MISALIGN_ERR_EN
    tbl.push_back('{LSU_LW,  32'h13,  32'h0,        32'h0,        1'b1});
    tbl.push_back('{LSU_SW,  32'h11,  32'h55555555, 32'h0,        1'b1});
    tbl.push_back('{LSU_LW,  32'h10,  32'h0,        32'h8001AAEF, 1'b0});
    tbl.push_back('{LSU_LH,  32'h13,  32'h0,        32'h0,        1'b1});
    tbl.push_back('{LSU_LW,  32'h110, 32'h0,        32'h8001AAEF, 1'b0});
    tbl.push_back('{LSU_LHU, 32'h10,  32'h0,        32'h0000AAEF, 1'b0});
    tbl.push_back('{LSU_LB,  32'h10,  32'h0,        32'hFFFFFFEF, 1'b0});
`else
    tbl.push_back('{LSU_LW,  32'h13,  32'h0,        32'h8001AAEF, 1'b0});
    tbl.push_back('{LSU_SW,  32'h11,  32'h55555555, 32'h0,        1'b0});
    tbl.push_back('{LSU_LW,  32'h10,  32'h0,        32'h55555555, 1'b0});
    tbl.push_back('{LSU_LH,  32'h13,  32'h0,        32'h00005555, 1'b0});
    tbl.push_back('{LSU_LW,  32'h110, 32'h0,        32'h55555555, 1'b0});
    tbl.push_back('{LSU_LHU, 32'h10,  32'h0,        32'h00005555, 1'b0});
    tbl.push_back('{LSU_LB,  32'h10,  32'h0,        32'h00000055, 1'b0});
`endif

    foreach (tbl[i]) begin
      model_apply(tbl[i].op, tbl[i].addr, tbl[i].wdata, drd, der);
      access(tbl[i].op, tbl[i].addr, tbl[i].wdata, (i == 1) ? 5 : 0, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(W + 1));
    end

    // Stall a load for 5 cycles with a competing request pending.
    run_model("stall_load", LSU_LW, 32'h24, 32'h0, 5);

    // Reset in the middle of the wait states of a store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = LSU_SW;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_rel_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_rel_ready", 32'(bus.req_ready), 32'd1);
    access(LSU_LW, 32'h20, 32'h0, 0, rd, er, lat);
    chk("abort_lw_prior", rd, pattern(8));

    for (int n = 0; n < 150; n++) begin
      run_model("rand", lsu_op_e'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
